// File: rtl/adder_disp_pkg.sv
// rtl/adder_disp_pkg.sv - shared FSM states, segment codes and sizing helper for adder_bcd_display
package adder_disp_pkg;

    typedef enum logic [1:0] {IDLE, CALC, CONV, SHOW} state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Decimal digits required to show the largest W+1 bit magnitude.
    function automatic int bcd_digits_needed(input int w);
        longint unsigned maxv;
        int              n;
        maxv = (64'd1 << (w + 1)) - 64'd1;
        n    = 0;
        while (maxv != 0) begin
            n    = n + 1;
            maxv = maxv / 64'd10;
        end
        return n;
    endfunction

endpackage

// File: rtl/adder_bcd_display_seg7_decode.sv
// rtl/adder_bcd_display_seg7_decode.sv - BCD nibble to active-low gfedcba segment decoder
module seg7_decode
    import adder_disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/adder_bcd_display.sv
// rtl/adder_bcd_display.sv - sequential add/subtract with double-dabble decimal 7-segment readout
module adder_bcd_display
    import adder_disp_pkg::*;
#(
    parameter int W      = 3,
    parameter int DIGITS = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [W-1:0]          A,
    input  logic [W-1:0]          B,
    input  logic                  CIN,
    input  logic                  SUB,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  NEG,
    output logic [7*DIGITS-1:0]   HEX_D,
    output logic [DIGITS-1:0]     HEX_DP
);

    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;

    generate
        if (DIGITS < bcd_digits_needed(W)) begin : g_digits_too_few
            $error("adder_bcd_display: DIGITS too small for W");
        end
    endgenerate

    state_t              state;
    logic                armed;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                cin_q;
    logic                sub_q;
    logic [W:0]          mag;
    logic                neg_pend;
    logic [BW-1:0]       bcd;
    logic [CW-1:0]       cnt;
    logic [W:0]          sum_full;
    logic [W:0]          diff_full;
    logic [BW-1:0]       bcd_adj;
    logic                bcd_adj_top_unused;
    logic [7*DIGITS-1:0] seg_dec;
    logic [DIGITS-1:0]   dp_next;

    always_comb begin
        sum_full  = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        diff_full = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, cin_q};
        bcd_adj   = bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        dp_next           = '1;
        dp_next[DIGITS-1] = ~neg_pend;
    end

    // The top adjusted bit is shifted out; the digit count guarantees it is zero.
    assign bcd_adj_top_unused = bcd_adj[BW-1];

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_dig
            seg7_decode u_dec (
                .bcd (bcd[4*k +: 4]),
                .seg (seg_dec[7*k +: 7])
            );
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= IDLE;
            armed    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            sub_q    <= 1'b0;
            mag      <= '0;
            neg_pend <= 1'b0;
            bcd      <= '0;
            cnt      <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            NEG      <= 1'b0;
            HEX_D    <= {DIGITS{SEG_0}};
            HEX_DP   <= '1;
        end else begin
            // armed blocks a START that coincides with the edge releasing reset
            armed <= 1'b1;
            DONE  <= 1'b0;
            case (state)
                IDLE: begin
                    BUSY <= 1'b0;
                    if (START && armed && !BUSY) begin
                        a_q   <= A;
                        b_q   <= B;
                        cin_q <= CIN;
                        sub_q <= SUB;
                        state <= CALC;
                    end
                end
                CALC: begin
                    BUSY <= 1'b1;
                    if (sub_q && diff_full[W]) begin
                        mag      <= -diff_full;
                        neg_pend <= 1'b1;
                    end else begin
                        mag      <= sub_q ? diff_full : sum_full;
                        neg_pend <= 1'b0;
                    end
                    bcd   <= '0;
                    cnt   <= CW'(W);
                    state <= CONV;
                end
                CONV: begin
                    bcd <= {bcd_adj[BW-2:0], mag[W]};
                    mag <= {mag[W-1:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    HEX_D  <= seg_dec;
                    HEX_DP <= dp_next;
                    NEG    <= neg_pend;
                    DONE   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bcd_display.sv
// tb/tb_adder_bcd_display.sv - self-checking bench for adder_bcd_display (W=3/DIGITS=2 and W=8/DIGITS=3)
module tb_adder_bcd_display;

    localparam int LAT0 = 6;
    localparam int LAT1 = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  a0, b0;
    logic        cin0, sub0, start0, busy0, done0, neg0;
    logic [13:0] hex0;
    logic [1:0]  dp0;
    logic [7:0]  a1, b1;
    logic        cin1, sub1, start1, busy1, done1, neg1;
    logic [20:0] hex1;
    logic [2:0]  dp1;

    int total = 0;
    int bad   = 0;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    adder_bcd_display u0 (
        .CLOCK_50(clk), .RESET_N(rst_n), .A(a0), .B(b0), .CIN(cin0), .SUB(sub0),
        .START(start0), .BUSY(busy0), .DONE(done0), .NEG(neg0), .HEX_D(hex0), .HEX_DP(dp0)
    );

    adder_bcd_display #(.W(8), .DIGITS(3)) u1 (
        .CLOCK_50(clk), .RESET_N(rst_n), .A(a1), .B(b1), .CIN(cin1), .SUB(sub1),
        .START(start1), .BUSY(busy1), .DONE(done1), .NEG(neg1), .HEX_D(hex1), .HEX_DP(dp1)
    );

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] hex2_of(input int m);
        return {seg_of((m / 10) % 10), seg_of(m % 10)};
    endfunction

    function automatic logic [20:0] hex3_of(input int m);
        return {seg_of((m / 100) % 10), seg_of((m / 10) % 10), seg_of(m % 10)};
    endfunction

    task automatic calc(input int a, input int b, input int cin, input int sub,
                        output int m, output logic n);
        int d;
        if (sub != 0) begin
            d = a - b - cin;
            n = (d < 0);
            m = (d < 0) ? -d : d;
        end else begin
            m = a + b + cin;
            n = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model of the small instance: counts edges since an accepted START.
    int          m_k;
    logic        m_armed, m_busy, m_done, m_neg;
    logic [13:0] m_hex;
    logic [1:0]  m_dp;
    int          m_a, m_b, m_cin, m_sub;

    initial begin
        int   mm;
        logic nn;
        m_k = -1; m_armed = 0; m_busy = 0; m_done = 0; m_neg = 0;
        m_hex = hex2_of(0); m_dp = 2'b11;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_k = -1; m_armed = 0; m_busy = 0; m_done = 0; m_neg = 0;
                m_hex = hex2_of(0); m_dp = 2'b11;
            end else begin
                if (m_k < 0) begin
                    if (start0 && m_armed) begin
                        m_a = a0; m_b = b0; m_cin = cin0; m_sub = sub0;
                        m_k = 0;
                    end
                end else begin
                    m_k++;
                    if (m_k == LAT0) begin
                        calc(m_a, m_b, m_cin, m_sub, mm, nn);
                        m_hex = hex2_of(mm);
                        m_neg = nn;
                        m_dp  = nn ? 2'b01 : 2'b11;
                    end
                    if (m_k == LAT0 + 1) m_k = -1;
                end
                m_armed = 1;
                m_busy  = (m_k >= 1);
                m_done  = (m_k == LAT0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (check_en) begin
                check("cyc_hex0", hex0, m_hex);
                check("cyc_dp0", dp0, m_dp);
                check("cyc_neg0", neg0, m_neg);
                check("cyc_busy0", busy0, m_busy);
                check("cyc_done0", done0, m_done);
            end
        end
    end

    task automatic run0(input int a, input int b, input int cin, input int sub, output int lat);
        @(negedge clk);
        a0 = 3'(a); b0 = 3'(b); cin0 = 1'(cin); sub0 = 1'(sub); start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        lat = 0;
        while (!done0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run1(input int a, input int b, input int cin, input int sub, output int lat);
        @(negedge clk);
        a1 = 8'(a); b1 = 8'(b); cin1 = 1'(cin); sub1 = 1'(sub); start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int   lat, dones, m;
        logic n;
        rst_n = 1'b0;
        a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; start0 = 0;
        a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; start1 = 0;
        @(posedge clk);
        check_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hex0", hex0, 14'b1000000_1000000);
        check("rst_dp0", dp0, 2'b11);
        check("rst_busy0", busy0, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_hex1", hex1, 21'b1000000_1000000_1000000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run0(7, 7, 1, 0, lat);
        check("add15_lat", lat, LAT0);
        check("add15_hex", hex0, {7'b1111001, 7'b0010010});
        check("add15_neg", neg0, 1'b0);
        check("add15_dp", dp0, 2'b11);
        @(negedge clk);
        check("add15_done_pulse", done0, 1'b0);

        run0(2, 5, 0, 1, lat);
        check("sub_m3_hex", hex0, {7'b1000000, 7'b0110000});
        check("sub_m3_neg", neg0, 1'b1);
        check("sub_m3_dp", dp0, 2'b01);

        run0(0, 0, 0, 0, lat);
        check("zero_lat", lat, LAT0);
        check("zero_hex", hex0, {7'b1000000, 7'b1000000});
        run0(0, 7, 1, 1, lat);
        check("sub_m8_hex", hex0, {7'b1000000, 7'b0000000});
        check("sub_m8_neg", neg0, 1'b1);

        // START held and operands churned while busy
        @(negedge clk);
        a0 = 3; b0 = 4; cin0 = 0; sub0 = 0; start0 = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done0) begin
                dones++;
                start0 = 1'b0;
            end
            a0 = 3'($urandom); b0 = 3'($urandom); cin0 = 1'($urandom); sub0 = 1'($urandom);
        end
        start0 = 1'b0;
        check("hold_start_dones", dones, 1);
        check("hold_start_hex", hex0, {7'b1000000, 7'b1111000});

        run0(7, 7, 1, 0, lat);
        check("pre_rst_hex", hex0, {7'b1111001, 7'b0010010});
        @(negedge clk);
        a0 = 3; b0 = 4; cin0 = 0; sub0 = 0; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hex", hex0, 14'b1000000_1000000);
        check("abort_busy", busy0, 1'b0);
        check("abort_done", done0, 1'b0);
        check("abort_neg", neg0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start0 = 1'b1;
        a0 = 5; b0 = 5;
        @(negedge clk);
        start0 = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 || busy0) dones++;
        end
        check("start_at_release_ignored", dones, 0);
        run0(1, 2, 0, 0, lat);
        check("post_rst_lat", lat, LAT0);
        check("post_rst_hex", hex0, {7'b1000000, 7'b0110000});

        run1(255, 255, 1, 0, lat);
        check("w8_511_lat", lat, LAT1);
        check("w8_511_hex", hex1, {7'b0010010, 7'b1111001, 7'b1111001});
        check("w8_511_dp", dp1, 3'b111);
        run1(0, 255, 1, 1, lat);
        check("w8_m256_hex", hex1, {7'b0100100, 7'b0010010, 7'b0000010});
        check("w8_m256_neg", neg1, 1'b1);
        check("w8_m256_dp", dp1, 3'b011);

        for (int i = 0; i < 30; i++) begin
            int a, b, c, s;
            a = $urandom_range(255); b = $urandom_range(255);
            c = $urandom_range(1);   s = $urandom_range(1);
            run1(a, b, c, s, lat);
            calc(a, b, c, s, m, n);
            check("sweep_lat", lat, LAT1);
            check("sweep_hex", hex1, hex3_of(m));
            check("sweep_neg", neg1, n);
            check("sweep_dp", dp1, n ? 3'b011 : 3'b111);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
